tipi_ti_bus_regs: RTL

TI-99/4A-side register bank of the TIPI PEB card, paired with the 4-bit Pi nibble bus block. It decodes asynchronous TI memory and CRU cycles in the `clk` domain and holds the TD and TC registers that the Pi bus block shifts out. It exposes the RD and RC registers (written by the Pi) as tear-free read data to the TI. It also owns the CRU enable bit and the Pi-reset request bit.

---
 rtl/tipi_ti_bus_regs.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tipi_ti_bus_regs.sv
// -----------------------------------------------------------------------------
// tipi_ti_bus_regs
//
// TI-99/4A-side register bank of the TIPI PEB card.
//
// This block decodes asynchronous TI memory and CRU bus cycles in the clk
// domain. It holds the TD and TC registers that the Pi nibble bus block
// shifts out. It presents the RD and RC registers, which the Pi writes, to
// the TI as snapshot read data, so a TI read never sees a half-updated value.
// It also owns the CRU enable bit (dsr_en) and the Pi reset request bit.
//
// Parameters
//   CRU_BASE     ti_addr[15:8] value that selects this card's CRU space
//
// Ports
//   clk          card clock, asynchronous to the TI bus
//   reset        asynchronous, active-high
//   ti_addr      TI address bus
//   ti_data_in   TI write data
//   ti_data_out  TI read data
//   ti_data_oe   drive enable for ti_data_out
//   ti_memen_n   memory cycle, active-low
//   ti_we_n      memory write strobe, active-low
//   ti_dbin      read cycle, active-high
//   ti_cruclk_n  CRU bit-write strobe, active-low
//   ti_cruout    CRU bit value
//   TD, TC       TI data / control registers, sent to the Pi bus block
//   RD, RC       Pi data / control registers, from the Pi bus block
//   tc_strobe    one-cycle pulse, coincident with each TC update
//   dsr_en       CRU bit 0: enables the DSR window and the registers
//   pi_reset     CRU bit 1: Pi reset request
//   dsr_rom_sel  DSR ROM select
// -----------------------------------------------------------------------------
module tipi_ti_bus_regs #(
   parameter logic [7:0] CRU_BASE = 8'h11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ti_addr,
   input  logic [7:0]  ti_data_in,
   output logic [7:0]  ti_data_out,
   output logic        ti_data_oe,
   input  logic        ti_memen_n,
   input  logic        ti_we_n,
   input  logic        ti_dbin,
   input  logic        ti_cruclk_n,
   input  logic        ti_cruout,
   output logic [7:0]  TD,
   output logic [7:0]  TC,
   input  logic [7:0]  RD,
   input  logic [7:0]  RC,
   output logic        tc_strobe,
   output logic        dsr_en,
   output logic        pi_reset,
   output logic        dsr_rom_sel
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_COMMIT
   } wr_state_t;

   // ---------------------------------------------------------------------
   // Strobe synchronizers ([0]=stage 1, [1]=stage 2, [2]=previous value)
   // and data pipes that stay aligned with stage 2
   // ---------------------------------------------------------------------
   logic [2:0]  we_sync;
   logic [2:0]  cruclk_sync;
   logic [1:0]  memen_sync;
   logic [1:0]  dbin_sync;
   logic [2:0]  sync_valid;
   logic [15:0] addr_p1, s_addr;
   logic [7:0]  data_p1, s_data;
   logic        cru_p1,  s_cru;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_sync     <= '1;
         cruclk_sync <= '1;
         memen_sync  <= '1;
         dbin_sync   <= '0;
         sync_valid  <= '0;
         addr_p1     <= '0;
         s_addr      <= '0;
         data_p1     <= '0;
         s_data      <= '0;
         cru_p1      <= 1'b0;
         s_cru       <= 1'b0;
      end else begin
         we_sync     <= {we_sync[1:0], ti_we_n};
         cruclk_sync <= {cruclk_sync[1:0], ti_cruclk_n};
         memen_sync  <= {memen_sync[0], ti_memen_n};
         dbin_sync   <= {dbin_sync[0], ti_dbin};
         sync_valid  <= {sync_valid[1:0], 1'b1};
         addr_p1     <= ti_addr;
         s_addr      <= addr_p1;
         data_p1     <= ti_data_in;
         s_data      <= data_p1;
         cru_p1      <= ti_cruout;
         s_cru       <= cru_p1;
      end
   end

   // The sync flops come out of reset at the inactive level, which would
   // fake a falling edge if a strobe was already low at release. sync_valid
   // marks when the previous-value flop holds a real sample; only then can
   // a falling edge start a cycle.
   logic we_fall, we_rise, cru_fall, cru_rise;
   logic mem_start;

   always_comb begin
      we_fall   = sync_valid[2] & we_sync[2] & ~we_sync[1];
      we_rise   = ~we_sync[2] & we_sync[1];
      cru_fall  = sync_valid[2] & cruclk_sync[2] & ~cruclk_sync[1];
      cru_rise  = ~cruclk_sync[2] & cruclk_sync[1];
      mem_start = we_fall & ~memen_sync[1];
   end

   // ---------------------------------------------------------------------
   // Memory write FSM
   // ---------------------------------------------------------------------
   wr_state_t mem_state, mem_next;
   logic      mem_capture, mem_commit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mem_state <= ST_IDLE;
      else       mem_state <= mem_next;
   end

   // Capture happens only on cycles where stage 2 of the strobe is low, so
   // the commit always uses the last address/data seen with the strobe low.
   always_comb begin
      mem_next    = mem_state;
      mem_capture = 1'b0;
      mem_commit  = 1'b0;
      case (mem_state)
         ST_IDLE: begin
            if (mem_start) begin
               mem_next    = ST_ACTIVE;
               mem_capture = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (we_rise) mem_next    = ST_COMMIT;
            else         mem_capture = 1'b1;
         end
         ST_COMMIT: begin
            mem_next   = ST_IDLE;
            mem_commit = 1'b1;
         end
         default: mem_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // CRU write FSM
   // ---------------------------------------------------------------------
   wr_state_t cru_state, cru_next;
   logic      cru_capture, cru_commit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cru_state <= ST_IDLE;
      else       cru_state <= cru_next;
   end

   always_comb begin
      cru_next    = cru_state;
      cru_capture = 1'b0;
      cru_commit  = 1'b0;
      case (cru_state)
         ST_IDLE: begin
            if (cru_fall) begin
               cru_next    = ST_ACTIVE;
               cru_capture = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (cru_rise) cru_next    = ST_COMMIT;
            else          cru_capture = 1'b1;
         end
         ST_COMMIT: begin
            cru_next   = ST_IDLE;
            cru_commit = 1'b1;
         end
         default: cru_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Captured cycle values
   // ---------------------------------------------------------------------
   logic [15:0] mem_cap_addr;
   logic [7:0]  mem_cap_data;
   logic [7:0]  cru_cap_base;
   logic [2:0]  cru_cap_idx;
   logic        cru_cap_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_cap_addr <= '0;
         mem_cap_data <= '0;
         cru_cap_base <= '0;
         cru_cap_idx  <= '0;
         cru_cap_val  <= 1'b0;
      end else begin
         if (mem_capture) begin
            mem_cap_addr <= s_addr;
            mem_cap_data <= s_data;
         end
         if (cru_capture) begin
            cru_cap_base <= s_addr[15:8];
            cru_cap_idx  <= s_addr[3:1];
            cru_cap_val  <= s_cru;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Register bank
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         TD        <= '0;
         TC        <= '0;
         tc_strobe <= 1'b0;
         dsr_en    <= 1'b0;
         pi_reset  <= 1'b0;
      end else begin
         tc_strobe <= 1'b0;
         if (mem_commit && dsr_en) begin
            case (mem_cap_addr)
               16'h5FFF: TD <= mem_cap_data;
               16'h5FFD: begin
                  TC        <= mem_cap_data;
                  tc_strobe <= 1'b1;
               end
               default: ;
            endcase
         end
         if (cru_commit && (cru_cap_base == CRU_BASE)) begin
            case (cru_cap_idx)
               3'd0:    dsr_en   <= cru_cap_val;
               3'd1:    pi_reset <= cru_cap_val;
               default: ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read snapshot: tracks RD/RC until the synced read is seen, then holds
   // ---------------------------------------------------------------------
   logic       read_active_s;
   logic [7:0] snap_rd, snap_rc;

   always_comb begin
      read_active_s = ~memen_sync[1] & dbin_sync[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_rd <= '0;
         snap_rc <= '0;
      end else if (!read_active_s) begin
         snap_rd <= RD;
         snap_rc <= RC;
      end
   end

   // ---------------------------------------------------------------------
   // Combinational read decode and ROM select on the raw bus
   // ---------------------------------------------------------------------
   logic rd_hit, rc_hit;

   always_comb begin
      rd_hit      = (ti_addr == 16'h5FFB);
      rc_hit      = (ti_addr == 16'h5FF9);
      ti_data_oe  = dsr_en & ~ti_memen_n & ti_dbin & (rd_hit | rc_hit);
      ti_data_out = '0;
      if (rd_hit)      ti_data_out = snap_rd;
      else if (rc_hit) ti_data_out = snap_rc;
      dsr_rom_sel = dsr_en & ~ti_memen_n &
                    (ti_addr >= 16'h4000) & (ti_addr <= 16'h5FF7);
   end

endmodule
